// File: rtl/menu_pkg.sv
// menu_pkg: shared system-state encoding and enabled-item search helpers for menu_ctrl
package menu_pkg;

   typedef enum logic [2:0] {
      ST_INTRO  = 3'd0,
      ST_GAME   = 3'd1,
      ST_PAUSE  = 3'd2,
      ST_RESULT = 3'd3,
      ST_HALT   = 3'd4
   } sys_state_t;

   localparam int MAX_ITEMS = 64;
   localparam int MAX_IW    = 6;

   function automatic int next_enabled_down(input logic [MAX_ITEMS-1:0] en, input int cur, input int n, input logic wrap);
      int res;
      int idx;
      logic found;
      res = cur;
      found = 1'b0;
      for (int k = 1; k < MAX_ITEMS; k++) begin
         idx = cur + k;
         if (wrap && idx >= n) idx = idx - n;
         if (!found && k < n && idx < n && en[idx[MAX_IW-1:0]]) begin
            res = idx;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   function automatic int next_enabled_up(input logic [MAX_ITEMS-1:0] en, input int cur, input int n, input logic wrap);
      int res;
      int idx;
      logic found;
      res = cur;
      found = 1'b0;
      for (int k = 1; k < MAX_ITEMS; k++) begin
         idx = cur - k;
         if (wrap && idx < 0) idx = idx + n;
         if (!found && k < n && idx >= 0 && idx < n && en[idx[MAX_IW-1:0]]) begin
            res = idx;
            found = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/btn_repeat.sv
// btn_repeat: rising-edge step pulse with hold-to-repeat when MENU_REPEAT_EN is defined
module btn_repeat #(
   parameter int DELAY_CYC = 50_000_000,
   parameter int RATE_CYC  = 10_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   input  logic en_i,
   output logic step_o
);

   logic prev_q;
   logic rise;

   // previous button level for edge detection
   always_ff @(posedge clk or posedge reset)
      if (reset) prev_q <= 1'b0;
      else prev_q <= btn_i;

   assign rise = btn_i & ~prev_q;

`ifdef MENU_REPEAT_EN
   localparam int MAXC = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
   localparam int CW   = $clog2(MAXC + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic rep_q, rep_d;
   logic fire;

   assign fire = btn_i & en_i & (cnt_q == (rep_q ? CW'(RATE_CYC) : CW'(DELAY_CYC)));

   // hold counter: counts from the rise, fires at the delay and then every rate period
   always_comb begin
      cnt_d = (btn_i & en_i) ? (fire ? CW'(1) : cnt_q + CW'(1)) : '0;
      rep_d = btn_i & en_i & (rep_q | fire);
   end

   // repeat counter state
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt_q <= '0;
         rep_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         rep_q <= rep_d;
      end

   assign step_o = en_i & (rise | fire);
`else
   logic unused_cfg;
   assign unused_cfg = ^{DELAY_CYC[0], RATE_CYC[0]};
   assign step_o = en_i & rise;
`endif

endmodule

// File: rtl/menu_ctrl.sv
// menu_ctrl: menu navigation, system FSM and game button gating; MENU_REPEAT_EN adds hold-to-repeat
module menu_ctrl
   import menu_pkg::*;
#(
   parameter int NUM_ITEMS        = 2,
   parameter int WRAP             = 1,
   parameter int REPEAT_DELAY_CYC = 50_000_000,
   parameter int REPEAT_RATE_CYC  = 10_000_000,
   parameter int IW               = $clog2(NUM_ITEMS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 btn_up,
   input  logic                 btn_down,
   input  logic                 btn_ok,
   input  logic                 btn_back,
   input  logic [NUM_ITEMS-1:0] item_enable,
   input  logic                 game_over,
   output logic [IW-1:0]        sel_idx,
   output logic [2:0]           sys_state,
   output logic                 start_pulse,
   output logic                 confirm_pulse,
   output logic [IW-1:0]        confirm_idx,
   output logic                 game_btn_ok,
   output logic                 game_btn_up
);

   sys_state_t state_q, state_d;
   logic [IW-1:0] sel_q, sel_d, cidx_q, cidx_d, nxt_dn, nxt_up;
   logic confirm_q, confirm_d, start_q, start_d;
   logic ok_prev_q, back_prev_q, ok_rise, back_rise;
   logic arm_ok_q, arm_ok_d, arm_up_q, arm_up_d;
   logic gok_q, gok_d, gup_q, gup_d;
   logic nav_en, up_step, down_step, in_game, game_entry;
   logic [NUM_ITEMS-1:0] en_eff;
   logic [MAX_ITEMS-1:0] en_ext;

   assign en_eff    = item_enable | NUM_ITEMS'(1);
   assign en_ext    = MAX_ITEMS'(en_eff);
   assign ok_rise   = btn_ok & ~ok_prev_q;
   assign back_rise = btn_back & ~back_prev_q;
   assign nav_en    = (state_q == ST_INTRO) & ~(btn_up & btn_down);
   assign nxt_dn    = IW'(next_enabled_down(en_ext, int'(sel_q), NUM_ITEMS, WRAP != 0));
   assign nxt_up    = IW'(next_enabled_up(en_ext, int'(sel_q), NUM_ITEMS, WRAP != 0));
   assign in_game   = state_q == ST_GAME;
   assign game_entry = (state_d == ST_GAME) & ~in_game;

   btn_repeat #(.DELAY_CYC(REPEAT_DELAY_CYC), .RATE_CYC(REPEAT_RATE_CYC)) u_up (
      .clk(clk), .reset(reset), .btn_i(btn_up), .en_i(nav_en), .step_o(up_step)
   );

   btn_repeat #(.DELAY_CYC(REPEAT_DELAY_CYC), .RATE_CYC(REPEAT_RATE_CYC)) u_down (
      .clk(clk), .reset(reset), .btn_i(btn_down), .en_i(nav_en), .step_o(down_step)
   );

   // system FSM next state and confirm/start pulses
   always_comb begin
      state_d   = state_q;
      confirm_d = 1'b0;
      start_d   = 1'b0;
      cidx_d    = cidx_q;
      case (state_q)
         ST_INTRO: if (ok_rise) begin
            confirm_d = 1'b1;
            cidx_d    = sel_q;
            if (sel_q == '0) begin
               state_d = ST_GAME;
               start_d = 1'b1;
            end else if (sel_q == IW'(NUM_ITEMS-1)) state_d = ST_HALT;
         end
         ST_GAME:   state_d = game_over ? ST_RESULT : back_rise ? ST_PAUSE : ST_GAME;
         ST_PAUSE:  state_d = ok_rise ? ST_GAME : back_rise ? ST_INTRO : ST_PAUSE;
         ST_RESULT: state_d = ok_rise ? ST_INTRO : ST_RESULT;
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_INTRO;
      endcase
   end

   // selection: disabled item snaps to 0, returns to intro reset it, otherwise navigate
   always_comb begin
      sel_d = !en_eff[sel_q] ? '0 :
              (((state_q == ST_PAUSE) & ~ok_rise & back_rise) | ((state_q == ST_RESULT) & ok_rise)) ? '0 :
              down_step ? nxt_dn :
              up_step ? nxt_up : sel_q;
   end

   // game gating: arm only after the button is seen released inside the game
   always_comb begin
      arm_ok_d = game_entry ? 1'b0 : (in_game & ~btn_ok) ? 1'b1 : arm_ok_q;
      arm_up_d = game_entry ? 1'b0 : (in_game & ~btn_up) ? 1'b1 : arm_up_q;
      gok_d    = btn_ok & arm_ok_q & in_game;
      gup_d    = btn_up & arm_up_q & in_game;
   end

   // all state and registered outputs
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q     <= ST_INTRO;
         sel_q       <= '0;
         cidx_q      <= '0;
         confirm_q   <= 1'b0;
         start_q     <= 1'b0;
         ok_prev_q   <= 1'b0;
         back_prev_q <= 1'b0;
         arm_ok_q    <= 1'b0;
         arm_up_q    <= 1'b0;
         gok_q       <= 1'b0;
         gup_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         cidx_q      <= cidx_d;
         confirm_q   <= confirm_d;
         start_q     <= start_d;
         ok_prev_q   <= btn_ok;
         back_prev_q <= btn_back;
         arm_ok_q    <= arm_ok_d;
         arm_up_q    <= arm_up_d;
         gok_q       <= gok_d;
         gup_q       <= gup_d;
      end

   assign sel_idx       = sel_q;
   assign sys_state     = state_q;
   assign start_pulse   = start_q;
   assign confirm_pulse = confirm_q;
   assign confirm_idx   = cidx_q;
   assign game_btn_ok   = gok_q;
   assign game_btn_up   = gup_q;

endmodule

// File: tb/tb_menu_ctrl.sv
// tb_menu_ctrl: directed checks of menu_ctrl navigation, FSM, gating and (with MENU_REPEAT_EN) auto-repeat
module tb_menu_ctrl;

   logic clk = 1'b0;
   logic reset, btn_up, btn_down, btn_ok, btn_back, game_over;
   logic [3:0] item_enable;
   logic [1:0] sel_idx, confirm_idx, c_sel_idx, c_confirm_idx;
   logic [2:0] sys_state, c_sys_state;
   logic start_pulse, confirm_pulse, game_btn_ok, game_btn_up;
   logic c_start_pulse, c_confirm_pulse, c_game_btn_ok, c_game_btn_up;
   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   menu_ctrl #(.NUM_ITEMS(4), .WRAP(1), .REPEAT_DELAY_CYC(8), .REPEAT_RATE_CYC(3)) dut (
      .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_ok(btn_ok),
      .btn_back(btn_back), .item_enable(item_enable), .game_over(game_over),
      .sel_idx(sel_idx), .sys_state(sys_state), .start_pulse(start_pulse),
      .confirm_pulse(confirm_pulse), .confirm_idx(confirm_idx),
      .game_btn_ok(game_btn_ok), .game_btn_up(game_btn_up)
   );

   menu_ctrl #(.NUM_ITEMS(4), .WRAP(0), .REPEAT_DELAY_CYC(8), .REPEAT_RATE_CYC(3)) dut_clamp (
      .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_ok(btn_ok),
      .btn_back(btn_back), .item_enable(item_enable), .game_over(game_over),
      .sel_idx(c_sel_idx), .sys_state(c_sys_state), .start_pulse(c_start_pulse),
      .confirm_pulse(c_confirm_pulse), .confirm_idx(c_confirm_idx),
      .game_btn_ok(c_game_btn_ok), .game_btn_up(c_game_btn_up)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic press_down;
      btn_down = 1'b1;
      tick();
      btn_down = 1'b0;
      tick();
   endtask

   task automatic press_up;
      btn_up = 1'b1;
      tick();
      btn_up = 1'b0;
      tick();
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1;
      {btn_up, btn_down, btn_ok, btn_back, game_over} = '0;
      item_enable = 4'b1111;
      tick();
      tick();
      check("rst_state", sys_state, 0);
      check("rst_sel", sel_idx, 0);
      check("rst_confirm", confirm_pulse, 0);
      check("rst_start", start_pulse, 0);
      check("rst_gok", game_btn_ok, 0);
      reset = 1'b0;
      tick();
      press_down();
      check("down1", sel_idx, 1);
      press_down();
      check("down2", sel_idx, 2);
      press_down();
      check("down3", sel_idx, 3);
      check("clamp_down3", c_sel_idx, 3);
      press_down();
      check("down_wrap", sel_idx, 0);
      check("clamp_hold_end", c_sel_idx, 3);
      press_up();
      check("up_wrap", sel_idx, 3);
      check("clamp_up", c_sel_idx, 2);

      do_reset();
      item_enable = 4'b1011;
      press_down();
      check("skip_d1", sel_idx, 1);
      press_down();
      check("skip_d2", sel_idx, 3);
      check("clamp_skip", c_sel_idx, 3);
      press_down();
      check("skip_wrap", sel_idx, 0);
      check("clamp_skip_hold", c_sel_idx, 3);
      press_up();
      check("skip_up_wrap", sel_idx, 3);
      check("clamp_skip_up", c_sel_idx, 1);
      item_enable = 4'b0111;
      tick();
      check("disable_force0", sel_idx, 0);
      check("clamp_still_ok", c_sel_idx, 1);
      item_enable = 4'b0001;
      press_down();
      check("only_one_item", sel_idx, 0);
      item_enable = 4'b1111;
      tick();
      btn_up = 1'b1;
      btn_down = 1'b1;
      tick();
      tick();
      check("both_nomove", sel_idx, 0);
      btn_up = 1'b0;
      btn_down = 1'b0;
      tick();

      press_down();
      btn_ok = 1'b1;
      tick();
      check("mid_confirm", confirm_pulse, 1);
      check("mid_cidx", confirm_idx, 1);
      check("mid_state", sys_state, 0);
      check("mid_nostart", start_pulse, 0);
      btn_ok = 1'b0;
      tick();
      press_up();
      check("back_to0", sel_idx, 0);

      btn_ok = 1'b1;
      tick();
      check("start_confirm", confirm_pulse, 1);
      check("start_pulse", start_pulse, 1);
      check("start_state", sys_state, 1);
      check("start_cidx", confirm_idx, 0);
      tick();
      check("confirm_1cyc", confirm_pulse, 0);
      check("start_1cyc", start_pulse, 0);
      check("gok_gated", game_btn_ok, 0);
      btn_ok = 1'b0;
      tick();
      check("gok_rel", game_btn_ok, 0);
      btn_ok = 1'b1;
      tick();
      check("gok_pass", game_btn_ok, 1);
      btn_ok = 1'b0;
      tick();
      check("gok_low", game_btn_ok, 0);
      btn_up = 1'b1;
      tick();
      check("gup_pass", game_btn_up, 1);
      check("game_nonav", sel_idx, 0);
      btn_up = 1'b0;
      tick();

      btn_back = 1'b1;
      tick();
      check("pause", sys_state, 2);
      btn_back = 1'b0;
      tick();
      btn_ok = 1'b1;
      tick();
      check("resume", sys_state, 1);
      tick();
      check("resume_gok_gated", game_btn_ok, 0);
      btn_ok = 1'b0;
      tick();
      game_over = 1'b1;
      btn_back = 1'b1;
      tick();
      check("gameover_wins", sys_state, 3);
      game_over = 1'b0;
      btn_back = 1'b0;
      tick();
      btn_ok = 1'b1;
      tick();
      check("result_intro", sys_state, 0);
      check("result_sel0", sel_idx, 0);
      btn_ok = 1'b0;
      tick();

      press_down();
      press_down();
      press_down();
      check("halt_sel", sel_idx, 3);
      btn_ok = 1'b1;
      tick();
      check("halt_state", sys_state, 4);
      check("halt_confirm", confirm_pulse, 1);
      check("halt_cidx", confirm_idx, 3);
      check("halt_nostart", start_pulse, 0);
      btn_ok = 1'b0;
      tick();
      btn_ok = 1'b1;
      tick();
      check("halt_ignore_ok", confirm_pulse, 0);
      check("halt_stays", sys_state, 4);
      btn_ok = 1'b0;
      tick();
      press_down();
      check("halt_nonav", sel_idx, 3);
      reset = 1'b1;
      #1;
      check("async_reset_state", sys_state, 0);
      check("async_reset_sel", sel_idx, 0);
      reset = 1'b0;
      tick();
      tick();

      btn_down = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
`ifdef MENU_REPEAT_EN
         if (k == 1) check("rep_k1", sel_idx, 1);
         if (k == 8) check("rep_k8", sel_idx, 1);
         if (k == 9) check("rep_k9", sel_idx, 2);
         if (k == 12) check("rep_k12", sel_idx, 3);
         if (k == 15) check("rep_k15", sel_idx, 0);
         if (k == 18) check("rep_k18", sel_idx, 1);
         if (k == 20) check("rep_k20", sel_idx, 1);
`else
         if (k == 1 || k == 20) check("hold_single_step", sel_idx, 1);
`endif
      end
      btn_down = 1'b0;
      tick();
      btn_up = 1'b1;
      btn_down = 1'b1;
      for (int k = 1; k <= 20; k++) tick();
      check("both_held_nostep", sel_idx, 1);
      btn_up = 1'b0;
      btn_down = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
